multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences a shared-ALU multicycle RV32I datapath: fetch, decode, memory, writeback.
- Drives the Sign_extend ImmSrc select and all mux/enable controls.
- Supports lui, addi, beq/bne, lw/lb/lbu, sw/sb, jal and jalr. Any other encoding traps.
- Sits beside the datapath. op and funct3 come from the instruction register and are stable from DECODE until the next FETCH completes.

Parameters:
- OP_WIDTH, 7, opcode field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Synchronous, active-low (rst=0 resets).
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake: access completes in the cycle it is 1.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  instruction register / OldPC load.
- MemWrite  out  1  store strobe.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult, 11=ImmExt.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ImmExt, 10=constant 4.
- ALUControl  out  3  ALU operation: 000=add, 001=sub.
- ImmSrc  out  2  Sign_extend select: 01=extend, 00=off.
- illegal  out  1  sticky trap flag.

Behaviour:
- Reset: state register loads FETCH. While rst=0, all enables (PCWrite, IRWrite, MemWrite, RegWrite) are 0, illegal=0, and the other outputs are 0.
- Reset asserted mid-operation: takes effect at the next edge with no write completing. Enables drop combinationally.
- Default for every output not listed in a state: 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=01, add. This precomputes the branch/jal target into ALUOut. Next state:
  - op 3 with funct3 in {0,2,4}, or op 35 with funct3 in {0,2}: MEMADR.
  - op 19 with funct3 0: EXECI.
  - op 99 with funct3 in {0,1}: BRANCH.
  - op 111: JAL.
  - op 103 with funct3 0: JALR.
  - op 55: LUI.
  - anything else: TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=01, add. Go to MEMRD if op=3, MEMWR if op=35.
- MEMRD: AdrSrc=1. Wait for mem_ready=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWR: AdrSrc=1, MemWrite=1, held until the mem_ready=1 cycle inclusive, then FETCH.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=01, add, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=Zero for funct3=0, PCWrite=~Zero for funct3=1. Then FETCH.
- JAL: ResultSrc=00, PCWrite=1 (target from DECODE). ALU computes OldPC+4 (ALUSrcA=01, ALUSrcB=10). Then ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=01, add (rs1+imm into ALUOut). Then JALR2.
- JALR2: same outputs as JAL. Then ALUWB. rd is written only after rs1 has been consumed, so rd==rs1 is safe.
- LUI: ImmSrc=01, ResultSrc=11, RegWrite=1, then FETCH.
- TRAP: illegal=1, all enables 0. Absorbing until reset.
- Cycles per instruction with zero wait states:
  - lui: 3; beq/bne: 3; sw: 4.
  - addi, jal: 4.
  - jalr, lw: 5.
  - Each mem_ready=0 cycle adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum with 14 states.
  - Opcode constants: OP_LOAD=3, OP_IMM=19, OP_STORE=35, OP_BRANCH=99, OP_JALR=103, OP_JAL=111, OP_LUI=55.
  - Mux encodings for ResultSrc, ALUSrcA and ALUSrcB.
  - ALU_ADD and ALU_SUB.
- One sub-module, ctrl_outdec: purely combinational, maps state, funct3, Zero and mem_ready to the outputs. The top level holds the state register and next-state logic.

Test Plan:
- Hold rst=0 for 2 cycles with mem_ready=1 -> all enables 0. Release -> FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10.
- addi (op=19, f3=0), mem_ready=1 -> FETCH, DECODE, EXECI, ALUWB. RegWrite=1 only in the 4th cycle, ResultSrc=00 there.
- lw (op=3, f3=2) with mem_ready low for 2 cycles in MEMRD -> 7 cycles total. AdrSrc=1 throughout MEMRD, RegWrite=1 with ResultSrc=01 in the last cycle.
- beq (f3=0): Zero=1 -> PCWrite=1 in BRANCH. Zero=0 -> PCWrite=0. bne (f3=1) -> the inverse of both.
- jalr (op=103, f3=0) -> JALR then JALR2. PCWrite=1 with ResultSrc=00 in JALR2, then ALUWB with RegWrite=1.
- op=51 -> TRAP after DECODE: illegal=1 held for 10 cycles. rst=0 clears it and the next state is FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
package ctrl_pkg;

    // One state per micro-step of the multicycle sequence.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECI  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JAL    = 4'd9,
        S_JALR   = 4'd10,
        S_JALR2  = 4'd11,
        S_LUI    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    // Opcodes (instr[6:0]) of the supported instruction classes.
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_LUI    = 7'd55;

    // Result mux.
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // ALU A operand mux.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU B operand mux.
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operations.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Sign-extender enable.
    localparam logic [1:0] IMM_OFF = 2'b00;
    localparam logic [1:0] IMM_EXT = 2'b01;

    // Complete control word driven onto the datapath.
    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_outdec.sv
// Moore output decoder: turns the current state (plus the few live
// qualifiers) into the datapath control word.
module ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Control word per state; anything not set stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src     = 1'b0;
                ctrl.alu_src_a   = SRCA_PC;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.result_src  = RES_ALURESULT;
                // PC+4 and the instruction latch only when memory delivers.
                ctrl.ir_write    = mem_ready;
                ctrl.pc_write    = mem_ready;
            end
            S_DECODE: begin
                // Precompute OldPC+imm so BRANCH/JAL find the target in ALUOut.
                ctrl.alu_src_a   = SRCA_OLDPC;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.imm_src     = IMM_EXT;
                ctrl.alu_control = ALU_ADD;
            end
            S_MEMADR, S_EXECI, S_JALR: begin
                ctrl.alu_src_a   = SRCA_RD1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.imm_src     = IMM_EXT;
                ctrl.alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_READDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                // Strobe stays up through the completing cycle.
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a   = SRCA_RD1;
                ctrl.alu_src_b   = SRCB_RD2;
                ctrl.alu_control = ALU_SUB;
                ctrl.result_src  = RES_ALUOUT;
                case (funct3)
                    3'd0:    ctrl.pc_write = zero;
                    3'd1:    ctrl.pc_write = ~zero;
                    default: ctrl.pc_write = 1'b0;
                endcase
            end
            S_JAL, S_JALR2: begin
                // Jump to the target in ALUOut while the ALU forms OldPC+4 for rd.
                ctrl.result_src  = RES_ALUOUT;
                ctrl.pc_write    = 1'b1;
                ctrl.alu_src_a   = SRCA_OLDPC;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.alu_control = ALU_ADD;
            end
            S_LUI: begin
                ctrl.imm_src    = IMM_EXT;
                ctrl.result_src = RES_IMMEXT;
                ctrl.reg_write  = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: state register, next-state logic and
// reset gating of the decoded control word.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [2:0]          funct3,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUControl,
    output logic [1:0]          ImmSrc,
    output logic                illegal
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl_out;

    logic is_load, is_imm, is_store, is_branch, is_jalr, is_jal, is_lui;

    assign is_load   = (op == OP_WIDTH'(OP_LOAD));
    assign is_imm    = (op == OP_WIDTH'(OP_IMM));
    assign is_store  = (op == OP_WIDTH'(OP_STORE));
    assign is_branch = (op == OP_WIDTH'(OP_BRANCH));
    assign is_jalr   = (op == OP_WIDTH'(OP_JALR));
    assign is_jal    = (op == OP_WIDTH'(OP_JAL));
    assign is_lui    = (op == OP_WIDTH'(OP_LUI));

    // State register; rst low forces FETCH on the next edge.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    // Next-state: memory states wait on mem_ready, DECODE dispatches on op/funct3.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if ((is_load && (funct3 == 3'd0 || funct3 == 3'd2 || funct3 == 3'd4)) ||
                    (is_store && (funct3 == 3'd0 || funct3 == 3'd2)))
                    state_next = S_MEMADR;
                else if (is_imm && funct3 == 3'd0)
                    state_next = S_EXECI;
                else if (is_branch && (funct3 == 3'd0 || funct3 == 3'd1))
                    state_next = S_BRANCH;
                else if (is_jal)
                    state_next = S_JAL;
                else if (is_jalr && funct3 == 3'd0)
                    state_next = S_JALR;
                else if (is_lui)
                    state_next = S_LUI;
                else
                    state_next = S_TRAP;
            end
            // op is held stable, so only load/store can reach here.
            S_MEMADR: state_next = is_load ? S_MEMRD : (is_store ? S_MEMWR : S_TRAP);
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_EXECI:  state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JAL:    state_next = S_ALUWB;
            S_JALR:   state_next = S_JALR2;
            S_JALR2:  state_next = S_ALUWB;
            S_LUI:    state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    ctrl_outdec u_outdec (
        .state     (state),
        .funct3    (funct3),
        .zero      (Zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_dec)
    );

    // Reset kills every output immediately so no write can land mid-reset.
    always_comb begin
        ctrl_out = ctrl_dec;
        if (!rst) ctrl_out = '0;
    end

    assign PCWrite    = ctrl_out.pc_write;
    assign AdrSrc     = ctrl_out.adr_src;
    assign IRWrite    = ctrl_out.ir_write;
    assign MemWrite   = ctrl_out.mem_write;
    assign RegWrite   = ctrl_out.reg_write;
    assign ResultSrc  = ctrl_out.result_src;
    assign ALUSrcA    = ctrl_out.alu_src_a;
    assign ALUSrcB    = ctrl_out.alu_src_b;
    assign ALUControl = ctrl_out.alu_control;
    assign ImmSrc     = ctrl_out.imm_src;
    assign illegal    = ctrl_out.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a directed vector table, hand-written corner
// sequences and a randomized instruction stream checked against a
// per-instruction-class model of the expected control words.
module tb_multicycle_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_ctrl #(.OP_WIDTH(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal)
    );

    // Observed control word: {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,
    // ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal}
    logic [16:0] got;
    assign got = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- expected control words ----------------
    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic irw,
                                      input logic mw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic ill);
        return {pcw, adr, irw, mw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    function automatic logic [16:0] e_fetch(input logic mr);
        return v(mr, 0, mr, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_decode();
        return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 0);
    endfunction
    function automatic logic [16:0] e_rs1_imm();   // address / addi / jalr target
        return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0);
    endfunction
    function automatic logic [16:0] e_memrd();
        return v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_memwb();
        return v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_memwr();
        return v(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_aluwb();
        return v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_branch(input logic take);
        return v(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_jump();
        return v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00, 0);
    endfunction
    function automatic logic [16:0] e_lui();
        return v(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 2'b01, 0);
    endfunction
    function automatic logic [16:0] e_trap();
        return v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
    endfunction

    // Instruction class from the supported-encoding list.
    // 0=illegal 1=load 2=store 3=addi 4=branch 5=jal 6=jalr 7=lui
    function automatic int klass(input logic [6:0] o, input logic [2:0] f);
        if (o == 7'd3   && (f == 3'd0 || f == 3'd2 || f == 3'd4)) return 1;
        if (o == 7'd35  && (f == 3'd0 || f == 3'd2))              return 2;
        if (o == 7'd19  && f == 3'd0)                             return 3;
        if (o == 7'd99  && (f == 3'd0 || f == 3'd1))              return 4;
        if (o == 7'd111)                                          return 5;
        if (o == 7'd103 && f == 3'd0)                             return 6;
        if (o == 7'd55)                                           return 7;
        return 0;
    endfunction

    // ---------------- driver + checker ----------------
    // Drive one cycle's inputs, check the combinational outputs mid-cycle,
    // then advance to just past the next rising edge.
    task automatic step(input logic r, input logic mr, input logic z,
                        input logic [16:0] exp, input string nm);
        rst = r; mem_ready = mr; Zero = z;
        #2;
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: run one instruction with random memory waits and
    // random don't-care inputs, checking each cycle's control word.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f);
        logic mr;
        logic z;
        int   k;
        int   waits;
        op = o; funct3 = f;
        k = klass(o, f);
        // fetch: stalls until memory answers (bounded so the run always ends)
        waits = 0;
        do begin
            mr = (waits >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            step(1, mr, 1'($urandom_range(0, 1)), e_fetch(mr), "rnd_fetch");
            waits++;
        end while (!mr);
        step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_decode(), "rnd_decode");
        case (k)
            1: begin
                step(1, 1'($urandom_range(0, 1)), 0, e_rs1_imm(), "rnd_memadr");
                waits = 0;
                do begin
                    mr = (waits >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    step(1, mr, 0, e_memrd(), "rnd_memrd");
                    waits++;
                end while (!mr);
                step(1, 1'($urandom_range(0, 1)), 0, e_memwb(), "rnd_memwb");
            end
            2: begin
                step(1, 1'($urandom_range(0, 1)), 0, e_rs1_imm(), "rnd_memadr");
                waits = 0;
                do begin
                    mr = (waits >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    step(1, mr, 0, e_memwr(), "rnd_memwr");
                    waits++;
                end while (!mr);
            end
            3: begin
                step(1, 1'($urandom_range(0, 1)), 0, e_rs1_imm(), "rnd_execi");
                step(1, 1'($urandom_range(0, 1)), 0, e_aluwb(), "rnd_aluwb");
            end
            4: begin
                z = 1'($urandom_range(0, 1));
                // beq takes on equal, bne on not-equal
                step(1, 1'($urandom_range(0, 1)), z, e_branch((f == 3'd0) ? z : ~z), "rnd_branch");
            end
            5: begin
                step(1, 1'($urandom_range(0, 1)), 0, e_jump(), "rnd_jal");
                step(1, 1'($urandom_range(0, 1)), 0, e_aluwb(), "rnd_jal_wb");
            end
            6: begin
                step(1, 1'($urandom_range(0, 1)), 0, e_rs1_imm(), "rnd_jalr");
                step(1, 1'($urandom_range(0, 1)), 0, e_jump(), "rnd_jalr2");
                step(1, 1'($urandom_range(0, 1)), 0, e_aluwb(), "rnd_jalr_wb");
            end
            7: begin
                step(1, 1'($urandom_range(0, 1)), 0, e_lui(), "rnd_lui");
            end
            default: begin
                for (int i = 0; i < 3; i++)
                    step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e_trap(), "rnd_trap");
                step(0, 1, 0, '0, "rnd_trap_reset");
            end
        endcase
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        r;
        logic [6:0]  o;
        logic [2:0]  f;
        logic        z;
        logic        mr;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [6:0] o, input logic [2:0] f,
                                input logic z, input logic mr, input logic [16:0] exp);
        vec_t t;
        t.r = r; t.o = o; t.f = f; t.z = z; t.mr = mr; t.exp = exp;
        return t;
    endfunction

    logic [6:0] legal_op[8];
    logic [2:0] legal_f3[8];
    logic [6:0] bad_op[4];
    logic [2:0] bad_f3[4];

    initial begin
        rst = 1'b0; op = 7'd19; funct3 = 3'd0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset held 2 cycles with mem_ready=1: everything 0
        tbl.push_back(mk(0, 7'd19, 3'd0, 0, 1, '0));
        tbl.push_back(mk(0, 7'd19, 3'd0, 0, 1, '0));
        // addi: FETCH, DECODE, EXECI, ALUWB
        tbl.push_back(mk(1, 7'd19, 3'd0, 0, 1, e_fetch(1)));
        tbl.push_back(mk(1, 7'd19, 3'd0, 0, 1, e_decode()));
        tbl.push_back(mk(1, 7'd19, 3'd0, 0, 1, e_rs1_imm()));
        tbl.push_back(mk(1, 7'd19, 3'd0, 0, 1, e_aluwb()));
        // beq Zero=1 taken, beq Zero=0 not, bne inverse of both
        tbl.push_back(mk(1, 7'd99, 3'd0, 1, 1, e_fetch(1)));
        tbl.push_back(mk(1, 7'd99, 3'd0, 1, 1, e_decode()));
        tbl.push_back(mk(1, 7'd99, 3'd0, 1, 1, e_branch(1)));
        tbl.push_back(mk(1, 7'd99, 3'd0, 0, 1, e_fetch(1)));
        tbl.push_back(mk(1, 7'd99, 3'd0, 0, 1, e_decode()));
        tbl.push_back(mk(1, 7'd99, 3'd0, 0, 1, e_branch(0)));
        tbl.push_back(mk(1, 7'd99, 3'd1, 1, 1, e_fetch(1)));
        tbl.push_back(mk(1, 7'd99, 3'd1, 1, 1, e_decode()));
        tbl.push_back(mk(1, 7'd99, 3'd1, 1, 1, e_branch(0)));
        tbl.push_back(mk(1, 7'd99, 3'd1, 0, 1, e_fetch(1)));
        tbl.push_back(mk(1, 7'd99, 3'd1, 0, 1, e_decode()));
        tbl.push_back(mk(1, 7'd99, 3'd1, 0, 1, e_branch(1)));
        // lui: 3 cycles
        tbl.push_back(mk(1, 7'd55, 3'd5, 0, 1, e_fetch(1)));
        tbl.push_back(mk(1, 7'd55, 3'd5, 0, 1, e_decode()));
        tbl.push_back(mk(1, 7'd55, 3'd5, 0, 1, e_lui()));
        // sw: 4 cycles
        tbl.push_back(mk(1, 7'd35, 3'd2, 0, 1, e_fetch(1)));
        tbl.push_back(mk(1, 7'd35, 3'd2, 0, 1, e_decode()));
        tbl.push_back(mk(1, 7'd35, 3'd2, 0, 1, e_rs1_imm()));
        tbl.push_back(mk(1, 7'd35, 3'd2, 0, 1, e_memwr()));

        foreach (tbl[i]) begin
            op = tbl[i].o; funct3 = tbl[i].f;
            step(tbl[i].r, tbl[i].mr, tbl[i].z, tbl[i].exp, $sformatf("tbl[%0d]", i));
        end

        // lw with two wait states in MEMRD: 7 cycles
        op = 7'd3; funct3 = 3'd2;
        step(1, 1, 0, e_fetch(1), "lw_fetch");
        step(1, 0, 0, e_decode(), "lw_decode");
        step(1, 0, 0, e_rs1_imm(), "lw_memadr");
        step(1, 0, 0, e_memrd(), "lw_memrd_w1");
        step(1, 0, 0, e_memrd(), "lw_memrd_w2");
        step(1, 1, 0, e_memrd(), "lw_memrd_done");
        step(1, 0, 0, e_memwb(), "lw_memwb");

        // fetch stall: nothing latched until mem_ready
        op = 7'd103; funct3 = 3'd0;
        step(1, 0, 0, e_fetch(0), "jalr_fetch_stall");
        step(1, 1, 0, e_fetch(1), "jalr_fetch");
        step(1, 1, 0, e_decode(), "jalr_decode");
        step(1, 1, 0, e_rs1_imm(), "jalr_jalr");
        step(1, 1, 0, e_jump(), "jalr_jalr2");
        step(1, 1, 0, e_aluwb(), "jalr_aluwb");

        // reset in the middle of a store: strobe drops at once, then FETCH
        op = 7'd35; funct3 = 3'd0;
        step(1, 1, 0, e_fetch(1), "sb_fetch");
        step(1, 1, 0, e_decode(), "sb_decode");
        step(1, 1, 0, e_rs1_imm(), "sb_memadr");
        step(1, 0, 0, e_memwr(), "sb_memwr_wait");
        step(0, 1, 0, '0, "sb_reset_mid");
        step(1, 0, 0, e_fetch(0), "sb_after_reset");
        step(1, 1, 0, e_fetch(1), "sb_after_reset_go");
        op = 7'd111; funct3 = 3'd3;
        step(1, 0, 0, e_decode(), "jal_decode");
        step(1, 0, 0, e_jump(), "jal_jal");
        step(1, 0, 0, e_aluwb(), "jal_aluwb");

        // illegal op 51: sticky trap for 10 cycles, reset clears it
        op = 7'd51; funct3 = 3'd0;
        step(1, 1, 0, e_fetch(1), "trap_fetch");
        step(1, 1, 0, e_decode(), "trap_decode");
        for (int i = 0; i < 10; i++)
            step(1, 1'(i % 2), 1'(i % 3 == 0), e_trap(), $sformatf("trap_hold[%0d]", i));
        step(0, 1, 0, '0, "trap_reset");
        step(1, 1, 0, e_fetch(1), "trap_refetch");
        op = 7'd19; funct3 = 3'd0;
        step(1, 1, 0, e_decode(), "trap_next_decode");
        step(1, 1, 0, e_rs1_imm(), "trap_next_execi");
        step(1, 1, 0, e_aluwb(), "trap_next_aluwb");

        // randomized instruction stream
        legal_op = '{7'd3, 7'd3, 7'd35, 7'd19, 7'd99, 7'd111, 7'd103, 7'd55};
        legal_f3 = '{3'd0, 3'd4, 3'd2, 3'd0, 3'd1, 3'd6, 3'd0, 3'd7};
        bad_op   = '{7'd3, 7'd19, 7'd103, 7'd51};
        bad_f3   = '{3'd1, 3'd1, 3'd2, 3'd0};
        for (int n = 0; n < 200; n++) begin
            int idx;
            logic [2:0] f;
            if ($urandom_range(0, 9) == 0) begin
                idx = $urandom_range(0, 3);
                run_instr(bad_op[idx], bad_f3[idx]);
            end else begin
                idx = $urandom_range(0, 7);
                f = legal_f3[idx];
                // branch and load funct3 also randomised among legal values
                if (legal_op[idx] == 7'd99) f = 3'($urandom_range(0, 1));
                if (legal_op[idx] == 7'd3)  f = ($urandom_range(0, 1) == 1) ? 3'd2 : 3'd0;
                if (legal_op[idx] == 7'd111 || legal_op[idx] == 7'd55) f = 3'($urandom_range(0, 7));
                run_instr(legal_op[idx], f);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
